stage_execute_mdu: RTL and testbench
====================================

STAGE_EXECUTE_MDU -- requirements
Module: stage_execute_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal 28..64).
REQ-002 SHALL have parameter TARGET_W, default 27, jump-target field width.
REQ-003 SHALL have clock  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have in_valid  in  1 and in_ready  out  1  issue handshake from ID/EX latch.
REQ-006 SHALL have opcode, alu_op, shamt  in  5 each  decoded instruction fields.
REQ-007 SHALL have immediate  in  17 and target  in  TARGET_W  instruction fields.
REQ-008 SHALL have operand_a, operand_b, pc_plus_4  in  XLEN  rs value, rt/rd value, PC+1.
REQ-009 SHALL have flush  in  1  synchronous kill of in-flight and registered work.
REQ-010 SHALL have out_valid  out  1 and out_ready  in  1  result handshake to EX/MEM.
REQ-011 SHALL have o_out, b_out, pc_in  out  XLEN  result, store data/ALU B operand, next PC.
REQ-012 SHALL have take_branch, overflow, div_by_zero  out  1 each  registered status.

Function
REQ-013 SHALL accept an instruction on a cycle with in_valid & in_ready & ~flush.
REQ-014 SHALL drive in_ready = (state==IDLE) & (~out_valid | out_ready), combinationally.
REQ-015 SHALL use ALU B = sign-extended immediate for addi/sw/lw, 0 for bex, else operand_b.
REQ-016 SHALL complete add, sub, and, or, sll, sra, addi, lw, sw, branches, jumps with 1-cycle latency into the output register.
REQ-017 SHALL route R-type alu_op mul (00110) and div (00111) to the iterative unit; state IDLE->BUSY on accept.
REQ-018 SHALL remain in BUSY exactly XLEN cycles, then load the output register and return to IDLE in the same edge.
REQ-019 SHALL hold in_ready low throughout BUSY; operands SHALL be captured at accept.
REQ-020 SHALL hold all outputs stable while out_valid & ~out_ready; out_valid clears on transfer unless a new result loads.
REQ-021 SHALL flag overflow on signed overflow of add/sub/addi, and on mul products not representable in XLEN signed.
REQ-022 SHALL perform signed div truncating toward zero; divisor 0 -> o_out 0, div_by_zero 1, overflow 1; MIN/-1 -> o_out MIN, overflow 1.
REQ-023 SHALL resolve bne taken when operand_a != operand_b, blt when operand_a > operand_b (signed), bex when operand_a != 0.
REQ-024 SHALL set pc_in = pc_plus_4 + sext(immediate) for taken bne/blt.
REQ-025 SHALL set pc_in = {pc_plus_4[XLEN-1:TARGET_W], target} for j, jal, taken bex.
REQ-026 SHALL set pc_in = operand_b for jr, else pc_plus_4.
REQ-027 SHALL assert take_branch for taken bne/blt/bex, j, jal, jr; 0 otherwise, including all mul/div results.
REQ-028 SHALL, on flush, clear out_valid, abort BUSY to IDLE on the next edge, and drop any same-cycle issue.
REQ-029 SHALL treat unknown opcodes as 1-cycle ops with o_out 0, take_branch 0, pc_in = pc_plus_4.

Reset
REQ-030 SHALL, while reset_n low, force state IDLE, counter 0, out_valid 0, all data/status outputs 0.
REQ-031 SHALL abandon any BUSY operation on reset assertion; in_ready SHALL read 1 after release.

Structure
REQ-032 SHALL take opcode, alu_op and FSM state encodings from shared package exec_pkg.
REQ-033 SHALL instantiate one sub-module mdu_iter (shift-add multiply, restoring divide, XLEN-parameterised, start/done).

Verification
REQ-034 SHALL cover: addi operand_a=5, imm=-3 -> next cycle out_valid 1, o_out 2, overflow 0.
REQ-035 SHALL cover: mul 0x7FFFFFFF*2 -> in_ready 0 for 32 cycles, o_out 0xFFFFFFFE, overflow 1.
REQ-036 SHALL cover: div -7/2 -> o_out -3; div 9/0 -> o_out 0, div_by_zero 1.
REQ-037 SHALL cover: blt operand_a=3, operand_b=-1, pc_plus_4=100, imm=-4 -> take_branch 1, pc_in 96.
REQ-038 SHALL cover: flush asserted in BUSY cycle 10 -> out_valid never set, IDLE and in_ready 1 next cycle.
REQ-039 SHALL cover: out_ready held 0 with add result pending -> outputs stable, in_ready 0 until out_ready 1.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings for the execute stage.
//   state_t        : execute-stage FSM state (IDLE accepts, BUSY iterates mul/div)
//   OP_*           : 5-bit major opcodes
//   ALU_*          : 5-bit R-type alu_op codes
//   is_mdu_op()    : true when an instruction goes to the iterative mul/div unit
package exec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    function automatic logic is_mdu_op(input logic [4:0] opcode, input logic [4:0] alu_op);
        return (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative signed multiply (shift-add) / divide (restoring), one
// bit per cycle over XLEN cycles. Works on magnitudes and fixes the sign at
// the end.
//   clock, reset_n : clock, async active-low reset (counter only)
//   start          : load operands (one cycle, while caller is idle)
//   run            : caller is BUSY; advance one step per cycle
//   is_div, op_a, op_b : operation select and signed operands
//   done           : final step this cycle; result/flags valid combinationally
//   result, overflow, div_by_zero : final signed result and status
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   run,
    input  logic                   is_div,
    input  logic signed [XLEN-1:0] op_a,
    input  logic signed [XLEN-1:0] op_b,
    output logic                   done,
    output logic signed [XLEN-1:0] result,
    output logic                   overflow,
    output logic                   div_by_zero
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v);
        return v[XLEN-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Full-width product fits XLEN signed when its top XLEN+1 bits agree.
    function automatic logic fits_xlen(input logic signed [2*XLEN-1:0] p);
        return (p[2*XLEN-1:XLEN-1] == '0) || (p[2*XLEN-1:XLEN-1] == '1);
    endfunction

    logic [CNT_W-1:0] cnt_p1;
    logic [XLEN:0]    acc_p1;   // mul: running high half; div: remainder
    logic [XLEN-1:0]  lo_p1;    // mul: multiplier/low half; div: dividend/quotient
    logic [XLEN-1:0]  mag_b_p1;
    logic             neg_p1, is_div_p1, dbz_p1, min_ovf_p1;

    logic [XLEN:0]    acc_nx, sum, shifted, trial;
    logic [XLEN-1:0]  lo_nx;
    logic signed [2*XLEN-1:0] prod_s;
    logic signed [XLEN-1:0]   quo_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   cnt_p1 <= '0;
        else if (start) cnt_p1 <= '0;
        else if (run)   cnt_p1 <= cnt_p1 + 1'b1;
    end

    // ---- stage p1: operand capture at start, one iteration per run cycle
    always_ff @(posedge clock) begin
        if (start) begin
            acc_p1     <= '0;
            lo_p1      <= magnitude(op_a);
            mag_b_p1   <= magnitude(op_b);
            neg_p1     <= op_a[XLEN-1] ^ op_b[XLEN-1];
            is_div_p1  <= is_div;
            dbz_p1     <= (op_b == '0);
            min_ovf_p1 <= ($unsigned(op_a) == XMIN) && (op_b == '1);
        end else if (run) begin
            acc_p1 <= acc_nx;
            lo_p1  <= lo_nx;
        end
    end

    always_comb begin
        sum     = acc_p1 + (lo_p1[0] ? {1'b0, mag_b_p1} : '0);
        shifted = {acc_p1[XLEN-1:0], lo_p1[XLEN-1]};
        trial   = shifted - {1'b0, mag_b_p1};
        if (is_div_p1) begin
            // Restoring step: keep the subtraction only if it did not go negative.
            if (!trial[XLEN]) begin
                acc_nx = trial;
                lo_nx  = {lo_p1[XLEN-2:0], 1'b1};
            end else begin
                acc_nx = shifted;
                lo_nx  = {lo_p1[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nx = {1'b0, sum[XLEN:1]};
            lo_nx  = {sum[0], lo_p1[XLEN-1:1]};
        end
    end

    // ---- final step output, taken from the next-state values
    always_comb begin
        prod_s = neg_p1 ? -$signed({acc_nx[XLEN-1:0], lo_nx}) : $signed({acc_nx[XLEN-1:0], lo_nx});
        quo_s  = neg_p1 ? -$signed(lo_nx) : $signed(lo_nx);
        if (is_div_p1) begin
            result      = dbz_p1 ? '0 : (min_ovf_p1 ? $signed(XMIN) : quo_s);
            overflow    = dbz_p1 | min_ovf_p1;
            div_by_zero = dbz_p1;
        end else begin
            result      = prod_s[XLEN-1:0];
            overflow    = ~fits_xlen(prod_s);
            div_by_zero = 1'b0;
        end
    end

    assign done = run && (cnt_p1 == CNT_W'(XLEN-1));

endmodule

// File: rtl/stage_execute_mdu.sv
// stage_execute_mdu: execute stage with single-cycle ALU/branch/jump path and
// an iterative XLEN-cycle mul/div unit behind an IDLE/BUSY FSM.
//   clock, reset_n                  : clock, async active-low reset
//   in_valid/in_ready               : issue handshake from ID/EX
//   opcode, alu_op, shamt, immediate, target : decoded instruction fields
//   operand_a, operand_b, pc_plus_4 : rs value, rt/rd value, PC+1
//   flush                           : kill pending result and any BUSY operation
//   out_valid/out_ready             : result handshake to EX/MEM
//   o_out, b_out, pc_in             : result, ALU B / store data, next PC
//   take_branch, overflow, div_by_zero : registered status
module stage_execute_mdu
    import exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TARGET_W = 27
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          opcode,
    input  logic [4:0]          alu_op,
    input  logic [4:0]          shamt,
    input  logic [16:0]         immediate,
    input  logic [TARGET_W-1:0] target,
    input  logic [XLEN-1:0]     operand_a,
    input  logic [XLEN-1:0]     operand_b,
    input  logic [XLEN-1:0]     pc_plus_4,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     o_out,
    output logic [XLEN-1:0]     b_out,
    output logic [XLEN-1:0]     pc_in,
    output logic                take_branch,
    output logic                overflow,
    output logic                div_by_zero
);

    function automatic logic add_ovf(input logic signed [XLEN-1:0] a, b, s);
        return (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [XLEN-1:0] a, b, d);
        return (a[XLEN-1] != b[XLEN-1]) && (d[XLEN-1] != a[XLEN-1]);
    endfunction

    state_t state_p1;
    logic   accept, is_mdu;
    logic [XLEN-1:0] b_hold_p1, pc_hold_p1;

    logic signed [XLEN-1:0] a_s, b_s, imm_s, alu_b, sum, diff;
    logic [XLEN-1:0] res_o, res_pc, branch_pc, jump_pc;
    logic res_tb, res_ovf;

    logic mdu_done, mdu_ovf, mdu_dbz;
    logic signed [XLEN-1:0] mdu_result;

    assign a_s    = operand_a;
    assign b_s    = operand_b;
    assign imm_s  = {{(XLEN-17){immediate[16]}}, immediate};
    assign is_mdu = is_mdu_op(opcode, alu_op);

    assign in_ready = (state_p1 == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // ---- stage p0: single-cycle ALU, branch resolution and next-PC select
    always_comb begin
        alu_b = b_s;
        if ((opcode == OP_ADDI) || (opcode == OP_SW) || (opcode == OP_LW)) alu_b = imm_s;
        else if (opcode == OP_BEX)                                          alu_b = '0;
        sum       = a_s + alu_b;
        diff      = a_s - alu_b;
        branch_pc = pc_plus_4 + $unsigned(imm_s);
        jump_pc   = {pc_plus_4[XLEN-1:TARGET_W], target};
        res_o     = '0;
        res_pc    = pc_plus_4;
        res_tb    = 1'b0;
        res_ovf   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (alu_op)
                    ALU_ADD: begin res_o = sum;  res_ovf = add_ovf(a_s, alu_b, sum);  end
                    ALU_SUB: begin res_o = diff; res_ovf = sub_ovf(a_s, alu_b, diff); end
                    ALU_AND: res_o = operand_a & operand_b;
                    ALU_OR:  res_o = operand_a | operand_b;
                    ALU_SLL: res_o = a_s <<  shamt;
                    ALU_SRA: res_o = a_s >>> shamt;
                    default: res_o = '0;
                endcase
            end
            OP_ADDI: begin res_o = sum; res_ovf = add_ovf(a_s, alu_b, sum); end
            OP_SW, OP_LW: res_o = sum;
            OP_BNE: if (a_s != alu_b) begin res_tb = 1'b1; res_pc = branch_pc; end
            OP_BLT: if (a_s >  alu_b) begin res_tb = 1'b1; res_pc = branch_pc; end
            OP_BEX: if (a_s != alu_b) begin res_tb = 1'b1; res_pc = jump_pc;   end
            OP_J:   begin res_tb = 1'b1; res_pc = jump_pc; end
            OP_JAL: begin res_tb = 1'b1; res_pc = jump_pc; res_o = pc_plus_4; end
            OP_JR:  begin res_tb = 1'b1; res_pc = operand_b; end
            default: ;
        endcase
    end

    // ---- stage p1: mul/div side operands held for the BUSY result
    always_ff @(posedge clock) begin
        if (accept && is_mdu) begin
            b_hold_p1  <= operand_b;
            pc_hold_p1 <= pc_plus_4;
        end
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu_iter (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (accept && is_mdu),
        .run         (state_p1 == BUSY),
        .is_div      (alu_op == ALU_DIV),
        .op_a        (a_s),
        .op_b        (b_s),
        .done        (mdu_done),
        .result      (mdu_result),
        .overflow    (mdu_ovf),
        .div_by_zero (mdu_dbz)
    );

    // ---- output register: FSM plus result/status, held while stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_p1    <= IDLE;
            out_valid   <= 1'b0;
            o_out       <= '0;
            b_out       <= '0;
            pc_in       <= '0;
            take_branch <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state_p1  <= IDLE;
            out_valid <= 1'b0;
        end else if (state_p1 == BUSY) begin
            if (mdu_done) begin
                state_p1    <= IDLE;
                out_valid   <= 1'b1;
                o_out       <= mdu_result;
                b_out       <= b_hold_p1;
                pc_in       <= pc_hold_p1;
                take_branch <= 1'b0;
                overflow    <= mdu_ovf;
                div_by_zero <= mdu_dbz;
            end
        end else if (accept) begin
            if (is_mdu) begin
                state_p1  <= BUSY;
                out_valid <= 1'b0;
            end else begin
                out_valid   <= 1'b1;
                o_out       <= res_o;
                b_out       <= alu_b;
                pc_in       <= res_pc;
                take_branch <= res_tb;
                overflow    <= res_ovf;
                div_by_zero <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_execute_mdu.sv
module tb_stage_execute_mdu;
    localparam int XLEN     = 32;
    localparam int TARGET_W = 27;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [4:0]          opcode = '0, alu_op = '0, shamt = '0;
    logic [16:0]         immediate = '0;
    logic [TARGET_W-1:0] target = '0;
    logic [XLEN-1:0]     operand_a = '0, operand_b = '0, pc_plus_4 = '0;
    logic                flush = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [XLEN-1:0]     o_out, b_out, pc_in;
    logic                take_branch, overflow, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    stage_execute_mdu #(.XLEN(XLEN), .TARGET_W(TARGET_W)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .alu_op(alu_op), .shamt(shamt), .immediate(immediate),
        .target(target), .operand_a(operand_a), .operand_b(operand_b),
        .pc_plus_4(pc_plus_4), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .o_out(o_out), .b_out(b_out), .pc_in(pc_in),
        .take_branch(take_branch), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] o, b, pc;
        logic tb, ov, dbz, mdu, chk_o;
    } exp_t;

    function automatic logic fits32(input longint r);
        return (r >= -64'sd2147483648) && (r <= 64'sd2147483647);
    endfunction

    // Reference: plain 64-bit integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [4:0] opc, aop, sh, input logic [16:0] imm,
                                   input logic [26:0] tgt, input logic [31:0] a, b, pc4);
        exp_t e;
        longint sa, sb, si, r;
        logic [31:0] jpc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        si = longint'($signed(imm));
        jpc = {pc4[31:27], tgt};
        e = '0;
        e.b = b; e.pc = pc4; e.chk_o = 1'b1;
        case (opc)
            5'd0: case (aop)
                5'd0: begin r = sa + sb; e.o = r[31:0]; e.ov = !fits32(r); end
                5'd1: begin r = sa - sb; e.o = r[31:0]; e.ov = !fits32(r); end
                5'd2: e.o = a & b;
                5'd3: e.o = a | b;
                5'd4: e.o = a << sh;
                5'd5: e.o = $signed(a) >>> sh;
                5'd6: begin e.mdu = 1; r = sa * sb; e.o = r[31:0]; e.ov = !fits32(r); end
                5'd7: begin
                    e.mdu = 1;
                    if (sb == 0) begin e.o = 0; e.dbz = 1; e.ov = 1; end
                    else if (sa == -64'sd2147483648 && sb == -1) begin e.o = 32'h8000_0000; e.ov = 1; end
                    else begin r = sa / sb; e.o = r[31:0]; end
                end
                default: e.o = 0;
            endcase
            5'd5: begin r = sa + si; e.o = r[31:0]; e.ov = !fits32(r); e.b = si[31:0]; end
            5'd7, 5'd8: begin r = sa + si; e.o = r[31:0]; e.b = si[31:0]; end
            5'd2: begin e.chk_o = 0; if (sa != sb) begin e.tb = 1; r = longint'(pc4) + si; e.pc = r[31:0]; end end
            5'd6: begin e.chk_o = 0; if (sa > sb)  begin e.tb = 1; r = longint'(pc4) + si; e.pc = r[31:0]; end end
            5'd22: begin e.chk_o = 0; e.b = 0; if (sa != 0) begin e.tb = 1; e.pc = jpc; end end
            5'd1, 5'd3: begin e.chk_o = 0; e.tb = 1; e.pc = jpc; end
            5'd4: begin e.chk_o = 0; e.tb = 1; e.pc = b; end
            default: e.o = 0;
        endcase
        return e;
    endfunction

    task automatic do_op(input logic [4:0] opc, aop, sh, input logic [16:0] imm,
                         input logic [26:0] tgt, input logic [31:0] a, b, pc4, input int stall);
        exp_t e;
        int   busy_cyc;
        bit   got, ready_in_busy;
        string t;
        e = model(opc, aop, sh, imm, tgt, a, b, pc4);
        t = $sformatf("op%0d/%0d", opc, aop);
        @(negedge clock);
        check_eq({t, " idle_in_ready"}, in_ready, 1);
        check_eq({t, " idle_out_valid"}, out_valid, 0);
        opcode = opc; alu_op = aop; shamt = sh; immediate = imm; target = tgt;
        operand_a = a; operand_b = b; pc_plus_4 = pc4;
        out_ready = (stall == 0);
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        // Scramble inputs so results must come from values captured at accept.
        operand_a = $urandom; operand_b = $urandom; pc_plus_4 = $urandom;
        immediate = 17'($urandom); opcode = 5'($urandom);
        busy_cyc = 0; got = 0; ready_in_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) begin got = 1; break; end
            if (in_ready) ready_in_busy = 1;
            busy_cyc++;
        end
        check_eq({t, " result_arrived"}, got, 1);
        check_eq({t, " latency"}, busy_cyc, e.mdu ? 32 : 0);
        check_eq({t, " ready_low_busy"}, ready_in_busy, 0);
        if (e.chk_o) check_eq({t, " o_out"}, o_out, e.o);
        check_eq({t, " b_out"}, b_out, e.b);
        check_eq({t, " pc_in"}, pc_in, e.pc);
        check_eq({t, " take_branch"}, take_branch, e.tb);
        check_eq({t, " overflow"}, overflow, e.ov);
        check_eq({t, " div_by_zero"}, div_by_zero, e.dbz);
        for (int k = 0; k < stall; k++) begin
            check_eq({t, " stall_in_ready"}, in_ready, 0);
            @(negedge clock);
            check_eq({t, " stall_valid"}, out_valid, 1);
            if (e.chk_o) check_eq({t, " stall_o_out"}, o_out, e.o);
            check_eq({t, " stall_pc_in"}, pc_in, e.pc);
        end
        out_ready = 1'b1;
        #1;
        check_eq({t, " ready_after_release"}, in_ready, 1);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'h8000_0000;
            5: v = $urandom_range(0, 20);
            6: v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic issue_mdu(input logic [4:0] aop, input logic [31:0] a, b);
        @(negedge clock);
        opcode = 5'd0; alu_op = aop; operand_a = a; operand_b = b;
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic watch_no_valid(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1;
        end
        check_eq(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected TB_RESULT");
        $fatal(1, "watchdog expired");
    end

    logic [4:0] opc_tab [13];
    logic [4:0] r_opc, r_aop;
    int         stall;

    initial begin
        opc_tab = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd7, 5'd8, 5'd1, 5'd3, 5'd4, 5'd2, 5'd6, 5'd22, 5'd0};

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst in_ready", in_ready, 1);
        check_eq("rst o_out", o_out, 0);
        check_eq("rst b_out", b_out, 0);
        check_eq("rst pc_in", pc_in, 0);
        check_eq("rst status", {take_branch, overflow, div_by_zero}, 0);
        reset_n = 1'b1;

        // Directed scenarios
        do_op(5'd5, 5'd0, 5'd0, 17'h1FFFD, 27'd0, 32'd5, 32'd0, 32'd0, 0);          // addi 5 + -3
        do_op(5'd0, 5'd6, 5'd0, 17'd0, 27'd0, 32'h7FFF_FFFF, 32'd2, 32'd40, 0);      // mul overflow
        do_op(5'd0, 5'd7, 5'd0, 17'd0, 27'd0, -32'd7, 32'd2, 32'd44, 0);             // div -7/2
        do_op(5'd0, 5'd7, 5'd0, 17'd0, 27'd0, 32'd9, 32'd0, 32'd48, 0);              // div by zero
        do_op(5'd0, 5'd7, 5'd0, 17'd0, 27'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd52, 0); // MIN/-1
        do_op(5'd6, 5'd0, 5'd0, 17'h1FFFC, 27'd0, 32'd3, 32'hFFFF_FFFF, 32'd100, 0);  // blt taken
        do_op(5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 32'd10, 32'd20, 32'd8, 3);             // add, stalled
        do_op(5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 32'h7FFF_FFFF, 32'd1, 32'd8, 0);       // add overflow

        // Flush in BUSY cycle 10
        issue_mdu(5'd6, 32'd123, 32'd456);
        repeat (10) @(negedge clock);
        check_eq("busy10 in_ready", in_ready, 0);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check_eq("flush busy in_ready", in_ready, 1);
        watch_no_valid("flush busy no result");

        // Flush drops a same-cycle issue
        @(negedge clock);
        opcode = 5'd0; alu_op = 5'd0; operand_a = 32'd1; operand_b = 32'd2;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        check_eq("flush drop out_valid", out_valid, 0);
        check_eq("flush drop in_ready", in_ready, 1);

        // Flush clears a pending, stalled result
        @(negedge clock);
        opcode = 5'd0; alu_op = 5'd0; operand_a = 32'd1; operand_b = 32'd2;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check_eq("pending out_valid", out_valid, 1);
        check_eq("pending o_out", o_out, 3);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        check_eq("flush pending out_valid", out_valid, 0);
        out_ready = 1'b1;

        // Reset during BUSY
        issue_mdu(5'd7, 32'd1000, 32'd7);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("rst busy out_valid", out_valid, 0);
        check_eq("rst busy o_out", o_out, 0);
        check_eq("rst busy in_ready", in_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("post rst in_ready", in_ready, 1);
        watch_no_valid("rst busy no result");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            r_opc = opc_tab[$urandom_range(0, 12)];
            if ($urandom_range(0, 9) == 0) begin
                r_opc = 5'($urandom_range(9, 31));
                if (r_opc == 5'd22) r_opc = 5'd21;
            end
            r_aop = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) r_aop = 5'($urandom_range(8, 31));
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_op(r_opc, r_aop, 5'($urandom), 17'($urandom), 27'($urandom),
                  rand_operand(), rand_operand(), $urandom, stall);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
